// File: rtl/niosii_system_sysid_checker.sv
// rtl/niosii_system_sysid_checker.sv - Avalon-MM reader that checks the sysid ID and timestamp words
module niosii_system_sysid_checker #(
    parameter logic [31:0] EXPECTED_ID        = 32'h00000000,
    parameter logic [31:0] EXPECTED_TIMESTAMP = 32'd1396564150,
    parameter int          TIMEOUT_CYCLES     = 255
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        start,
    output logic        busy,
    output logic        done,
    output logic        pass,
    output logic        id_ok,
    output logic        ts_ok,
    output logic        timeout,
    output logic [31:0] id_value,
    output logic [31:0] ts_value,
    output logic        avm_address,
    output logic        avm_read,
    input  logic        avm_waitrequest,
    input  logic [31:0] avm_readdata,
    input  logic        avm_readdatavalid
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_RD_ID_REQ,
        S_RD_ID_WAIT,
        S_RD_TS_REQ,
        S_RD_TS_WAIT,
        S_DONE
    } state_t;

    localparam logic [15:0] TIMEOUT_LIMIT = 16'(TIMEOUT_CYCLES);

    state_t      state;
    state_t      next_state;
    logic [15:0] tmo_cnt;
    logic        limit_hit;
    logic        accept_start;
    logic        cap_id;
    logic        cap_ts;
    logic        abort;
    logic        id_match;
    logic        ts_match;
    logic        next_is_req;
    logic        in_xfer;

    assign id_match    = (avm_readdata == EXPECTED_ID);
    assign ts_match    = (avm_readdata == EXPECTED_TIMESTAMP);
    assign limit_hit   = (tmo_cnt >= TIMEOUT_LIMIT);
    assign next_is_req = (next_state == S_RD_ID_REQ) || (next_state == S_RD_TS_REQ);
    assign in_xfer     = (state != S_IDLE) && (state != S_DONE);
    assign busy        = in_xfer;

    // Next-state decode; an arriving accept or response takes priority over the timeout limit.
    always_comb begin
        next_state   = state;
        accept_start = 1'b0;
        cap_id       = 1'b0;
        cap_ts       = 1'b0;
        abort        = 1'b0;
        case (state)
            S_IDLE, S_DONE: begin
                if (start) begin
                    next_state   = S_RD_ID_REQ;
                    accept_start = 1'b1;
                end
            end
            S_RD_ID_REQ: begin
                if (!avm_waitrequest) begin
                    next_state = S_RD_ID_WAIT;
                end else if (limit_hit) begin
                    next_state = S_DONE;
                    abort      = 1'b1;
                end
            end
            S_RD_ID_WAIT: begin
                if (avm_readdatavalid) begin
                    next_state = S_RD_TS_REQ;
                    cap_id     = 1'b1;
                end else if (limit_hit) begin
                    next_state = S_DONE;
                    abort      = 1'b1;
                end
            end
            S_RD_TS_REQ: begin
                if (!avm_waitrequest) begin
                    next_state = S_RD_TS_WAIT;
                end else if (limit_hit) begin
                    next_state = S_DONE;
                    abort      = 1'b1;
                end
            end
            S_RD_TS_WAIT: begin
                if (avm_readdatavalid) begin
                    next_state = S_DONE;
                    cap_ts     = 1'b1;
                end else if (limit_hit) begin
                    next_state = S_DONE;
                    abort      = 1'b1;
                end
            end
            default: begin
                next_state = S_IDLE;
            end
        endcase
    end

    // State register plus registered bus outputs, derived from the next state so they change with it.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state       <= S_IDLE;
            avm_read    <= 1'b0;
            avm_address <= 1'b0;
        end else begin
            state       <= next_state;
            avm_read    <= next_is_req;
            avm_address <= (next_state == S_RD_TS_REQ) || (next_state == S_RD_TS_WAIT);
        end
    end

    // Per-transaction cycle counter: restarts on entry to each request phase and saturates.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            tmo_cnt <= 16'd0;
        end else if (next_is_req && (next_state != state)) begin
            tmo_cnt <= 16'd0;
        end else if (in_xfer && (tmo_cnt != 16'hFFFF)) begin
            tmo_cnt <= tmo_cnt + 16'd1;
        end
    end

    // Sticky result flags and captured words; cleared only by an accepted start or reset.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            done     <= 1'b0;
            pass     <= 1'b0;
            id_ok    <= 1'b0;
            ts_ok    <= 1'b0;
            timeout  <= 1'b0;
            id_value <= 32'd0;
            ts_value <= 32'd0;
        end else begin
            if (accept_start) begin
                done    <= 1'b0;
                pass    <= 1'b0;
                id_ok   <= 1'b0;
                ts_ok   <= 1'b0;
                timeout <= 1'b0;
            end
            if (cap_id) begin
                id_value <= avm_readdata;
                id_ok    <= id_match;
            end
            if (cap_ts) begin
                ts_value <= avm_readdata;
                ts_ok    <= ts_match;
                done     <= 1'b1;
                pass     <= id_ok & ts_match;
            end
            if (abort) begin
                done    <= 1'b1;
                timeout <= 1'b1;
                pass    <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_niosii_system_sysid_checker.sv
// tb/tb_niosii_system_sysid_checker.sv - directed scoreboard bench for the sysid checker
module tb_niosii_system_sysid_checker;

    localparam logic [31:0] EXP_ID = 32'h00000000;
    localparam logic [31:0] EXP_TS = 32'h533E11B6;
    localparam int          TMO    = 8;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic        busy, done, pass, id_ok, ts_ok, timeout;
    logic [31:0] id_value, ts_value;
    logic        avm_address, avm_read;
    logic        avm_waitrequest   = 1'b0;
    logic [31:0] avm_readdata      = 32'd0;
    logic        avm_readdatavalid = 1'b0;

    typedef struct {
        int          lat;
        logic        pass;
        logic        id_ok;
        logic        ts_ok;
        logic        tmo;
        logic [31:0] idv;
        logic [31:0] tsv;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;
    int   cyc    = 0;

    int          cfg_waits    = 0;
    int          cfg_lat      = 1;
    logic        cfg_stuck_ts = 1'b0;
    logic [31:0] cfg_id       = 32'h00000000;
    logic [31:0] cfg_ts       = 32'h533E11B6;
    logic        late_tog     = 1'b0;
    logic [31:0] model_idv    = 32'd0;
    logic [31:0] model_tsv    = 32'd0;

    int          pend_cnt  = 0;
    logic [31:0] pend_data = 32'd0;
    int          wait_left = 0;
    logic        in_req    = 1'b0;
    logic        late_seen = 1'b0;

    niosii_system_sysid_checker #(
        .EXPECTED_ID       (EXP_ID),
        .EXPECTED_TIMESTAMP(EXP_TS),
        .TIMEOUT_CYCLES    (TMO)
    ) dut (
        .clock            (clock),
        .reset            (reset),
        .start            (start),
        .busy             (busy),
        .done             (done),
        .pass             (pass),
        .id_ok            (id_ok),
        .ts_ok            (ts_ok),
        .timeout          (timeout),
        .id_value         (id_value),
        .ts_value         (ts_value),
        .avm_address      (avm_address),
        .avm_read         (avm_read),
        .avm_waitrequest  (avm_waitrequest),
        .avm_readdata     (avm_readdata),
        .avm_readdatavalid(avm_readdatavalid)
    );

    always #5 clock = ~clock;

    always @(posedge clock) cyc <= cyc + 1;

    // Sysid slave model: programmable wait states, response latency, stuck timestamp, late pulse.
    always @(posedge clock) begin
        #1;
        avm_readdatavalid = 1'b0;
        if (pend_cnt > 0) begin
            pend_cnt = pend_cnt - 1;
            if (pend_cnt == 0) begin
                avm_readdatavalid = 1'b1;
                avm_readdata      = pend_data;
            end
        end
        if (late_tog != late_seen) begin
            late_seen         = late_tog;
            avm_readdatavalid = 1'b1;
            avm_readdata      = 32'hDEADBEEF;
        end
        if (avm_read) begin
            if (!in_req) begin
                in_req    = 1'b1;
                wait_left = cfg_waits;
            end
            if (cfg_stuck_ts && avm_address) begin
                avm_waitrequest = 1'b1;
            end else if (wait_left > 0) begin
                avm_waitrequest = 1'b1;
                wait_left       = wait_left - 1;
            end else begin
                avm_waitrequest = 1'b0;
                in_req          = 1'b0;
                pend_cnt        = cfg_lat;
                pend_data       = avm_address ? cfg_ts : cfg_id;
            end
        end else begin
            avm_waitrequest = 1'b0;
            in_req          = 1'b0;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge clock);
        #2;
    endtask

    task automatic push_exp(input int lat, input logic tmo);
        exp_t e;
        e.lat   = lat;
        e.tmo   = tmo;
        e.id_ok = (cfg_id === EXP_ID);
        e.ts_ok = tmo ? 1'b0 : (cfg_ts === EXP_TS);
        e.pass  = !tmo && e.id_ok && e.ts_ok;
        model_idv = cfg_id;
        if (!tmo) model_tsv = cfg_ts;
        e.idv = model_idv;
        e.tsv = model_tsv;
        sb.push_back(e);
    endtask

    task automatic do_start(output int n, input string tag, input int lat, input logic tmo);
        push_exp(lat, tmo);
        start = 1'b1;
        n     = cyc;
        tick();
        start = 1'b0;
        chk({tag, "_busy_n1"}, busy, 1);
        chk({tag, "_read_n1"}, avm_read, 1);
        chk({tag, "_addr_n1"}, avm_address, 0);
        chk({tag, "_done_clr"}, done, 0);
        chk({tag, "_pass_clr"}, pass, 0);
        chk({tag, "_idok_clr"}, id_ok, 0);
        chk({tag, "_tsok_clr"}, ts_ok, 0);
        chk({tag, "_tmo_clr"}, timeout, 0);
    endtask

    task automatic finish_check(input int n, input string tag);
        exp_t e;
        logic pr, pw, pa, got;
        pr = 1'b0; pw = 1'b0; pa = 1'b0; got = 1'b0;
        for (int k = 0; k < 300; k++) begin
            if (done === 1'b1) begin
                got = 1'b1;
                break;
            end
            if (pr && pw) begin
                chk({tag, "_hold_read"}, avm_read, 1);
                chk({tag, "_hold_addr"}, avm_address, pa);
            end
            pr = avm_read; pw = avm_waitrequest; pa = avm_address;
            tick();
        end
        chk({tag, "_done_seen"}, got, 1);
        if (sb.size() == 0) begin
            chk({tag, "_sb_nonempty"}, 0, 1);
            return;
        end
        e = sb.pop_front();
        if (got) begin
            chk({tag, "_latency"}, 32'(cyc - n), 32'(e.lat));
            chk({tag, "_busy"}, busy, 0);
            chk({tag, "_pass"}, pass, e.pass);
            chk({tag, "_id_ok"}, id_ok, e.id_ok);
            chk({tag, "_ts_ok"}, ts_ok, e.ts_ok);
            chk({tag, "_timeout"}, timeout, e.tmo);
            chk({tag, "_id_value"}, id_value, e.idv);
            chk({tag, "_ts_value"}, ts_value, e.tsv);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired observed=running required=finished");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;

        tick(); tick(); tick();
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_pass", pass, 0);
        chk("rst_read", avm_read, 0);
        chk("rst_addr", avm_address, 0);
        chk("rst_idv", id_value, 0);
        chk("rst_tsv", ts_value, 0);
        reset = 1'b0;
        tick();

        cfg_waits = 0; cfg_lat = 1; cfg_id = 32'h00000000; cfg_ts = 32'h533E11B6;
        do_start(n, "t1", 5, 1'b0);
        finish_check(n, "t1");
        tick();

        cfg_waits = 3; cfg_lat = 2;
        do_start(n, "t2", 13, 1'b0);
        finish_check(n, "t2");
        tick();

        cfg_waits = 0; cfg_lat = 1; cfg_id = 32'h00000001;
        do_start(n, "t3", 5, 1'b0);
        finish_check(n, "t3");
        tick();

        cfg_id = 32'h00000000; cfg_stuck_ts = 1'b1;
        do_start(n, "t4", 2 + cfg_waits + cfg_lat + TMO + 1, 1'b1);
        finish_check(n, "t4");
        chk("t4_read_dropped", avm_read, 0);
        cfg_stuck_ts = 1'b0;
        late_tog = ~late_tog;
        tick(); tick(); tick();
        chk("t4_late_tsv", ts_value, model_tsv);
        chk("t4_late_done", done, 1);
        chk("t4_late_tmo", timeout, 1);

        do_start(n, "t5", 5, 1'b0);
        tick();
        start = 1'b1;
        tick();
        start = 1'b0;
        finish_check(n, "t5");
        tick(); tick(); tick();
        chk("t5_no_rerun_busy", busy, 0);
        chk("t5_no_rerun_done", done, 1);

        cfg_lat = 2;
        do_start(n, "t6", 0, 1'b0);
        tick(); tick(); tick(); tick();
        chk("t6_pre_busy", busy, 1);
        reset = 1'b1;
        #1;
        chk("t6_busy", busy, 0);
        chk("t6_done", done, 0);
        chk("t6_pass", pass, 0);
        chk("t6_id_ok", id_ok, 0);
        chk("t6_ts_ok", ts_ok, 0);
        chk("t6_tmo", timeout, 0);
        chk("t6_idv", id_value, 0);
        chk("t6_tsv", ts_value, 0);
        chk("t6_read", avm_read, 0);
        chk("t6_addr", avm_address, 0);
        void'(sb.pop_back());
        model_idv = 32'd0;
        model_tsv = 32'd0;
        tick(); tick();
        reset = 1'b0;
        tick(); tick(); tick();
        cfg_lat = 1;
        do_start(n, "t6b", 5, 1'b0);
        finish_check(n, "t6b");

        cfg_id = 32'h00000001;
        do_start(n, "t7", 5, 1'b0);
        finish_check(n, "t7");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
